fila_param: RTL and testbench
=============================

FILA_PARAM -- requirements
Module: fila_param

Interface
REQ-001 Parameter DATA_W, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-003 Parameter LEN_W, default $clog2(DEPTH)+1, width of len_out.
REQ-004 clock_10KHz  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 enqueue_in  in  1  write request, level; acted on at its rising edge only.
REQ-007 dequeue_in  in  1  read request, level; acted on at its rising edge only.
REQ-008 clear_in  in  1  synchronous flush of contents and flags.
REQ-009 mode_lifo_in  in  1  0 = FIFO order, 1 = LIFO order; latched only while empty.
REQ-010 data_in  in  DATA_W  word written on an accepted enqueue.
REQ-011 data_out  out  DATA_W  last word removed; holds until next accepted dequeue.
REQ-012 data_valid_out  out  1  one-cycle pulse in the cycle data_out updates.
REQ-013 len_out  out  LEN_W  current occupancy, 0..DEPTH.
REQ-014 full_out / empty_out  out  1 each  len_out == DEPTH / len_out == 0.
REQ-015 overflow_out / underflow_out  out  1 each  sticky error flags.

Function
REQ-016 Each request input SHALL be registered once; event = input high AND registered copy low; a held level SHALL cause exactly one event.
REQ-017 Control SHALL be an FSM with states IDLE, OP, FLUSH; IDLE -> OP on any event; OP -> IDLE after one cycle; any state -> FLUSH on clear_in; FLUSH -> IDLE next cycle.
REQ-018 An event detected at edge N SHALL commit at edge N+1 (OP state); data_out, len_out, data_valid_out update at that edge.
REQ-019 Accepted enqueue (not full): write data_in at write pointer, pointer +1 mod DEPTH, len +1.
REQ-020 Accepted dequeue (not empty), FIFO: data_out <= entry at head, head +1 mod DEPTH, len -1.
REQ-021 Accepted dequeue, LIFO: data_out <= most recently written entry, write pointer -1 mod DEPTH, len -1.
REQ-022 Simultaneous enqueue and dequeue events: both SHALL commit in the same OP cycle, len unchanged.
REQ-023 Simultaneous when empty: FIFO SHALL pass data_in straight to data_out with data_valid pulse, len stays 0; LIFO SHALL do the same.
REQ-024 Simultaneous when full: both commit (dequeue frees the slot); LIFO returns the pre-existing top word.
REQ-025 Enqueue event when full (no dequeue): SHALL be dropped, overflow_out set, len unchanged.
REQ-026 Dequeue event when empty (no enqueue): SHALL be dropped, underflow_out set, data_out unchanged, no data_valid pulse.
REQ-027 Events arriving while in OP or FLUSH SHALL be dropped silently (no flag).
REQ-028 Pointers SHALL wrap modulo DEPTH; len arithmetic SHALL never wrap.
REQ-029 mode_lifo_in SHALL be copied into the active mode only when empty_out = 1; changes while non-empty are ignored until empty.
REQ-030 FLUSH SHALL zero pointers, len, overflow and underflow; storage contents are don't-care; data_out is preserved.

Reset
REQ-031 On reset: state IDLE, pointers 0, len_out 0, data_out 0, data_valid_out 0, overflow/underflow 0, active mode FIFO, registered request copies 0.
REQ-032 Reset asserted mid-OP SHALL abort the operation; no partial write or len change survives.
REQ-033 Storage array SHALL not require reset; reads of unwritten entries are unreachable by construction.

Structure
REQ-034 Package fila_pkg SHALL hold the FSM state enum (IDLE, OP, FLUSH) and the mode enum (FIFO, LIFO).
REQ-035 Sub-module detector_borda (one registered input, rising-edge pulse out, async reset) SHALL be instantiated for enqueue_in and dequeue_in.

Verification
REQ-036 Reset; enqueue 0x11,0x22,0x33 (FIFO); dequeue x3 -> data_out 0x11,0x22,0x33, len 3->0, three data_valid pulses.
REQ-037 Fill DEPTH=8 with 0x00..0x07; one more enqueue 0xAA -> overflow_out=1, len 8; dequeue x8 returns 0x00..0x07; wrap past pointer 7 verified by second fill.
REQ-038 LIFO, empty: enqueue 0x01,0x02,0x03; dequeue x3 -> 0x03,0x02,0x01; toggling mode while len=2 has no effect.
REQ-039 len=3, simultaneous enqueue 0x5A + dequeue -> len 3, data_out = oldest word; empty + simultaneous 0x77 -> data_out 0x77, len 0.
REQ-040 Dequeue when empty -> underflow_out=1, no pulse; clear_in -> flags 0, len 0; hold enqueue_in high 10 cycles -> len +1 only.
REQ-041 Assert reset one cycle after an enqueue event -> len 0, data_out 0, state IDLE.

Source files
------------

// File: rtl/fila_pkg.sv
// fila_pkg: shared FSM state and queue-order types for the fila_param queue.
package fila_pkg;
    typedef enum logic [1:0] {IDLE, OP, FLUSH} state_t;
    typedef enum logic {FIFO, LIFO} mode_t;
endpackage

// File: rtl/fila_param_detector_borda.sv
// detector_borda: one-cycle pulse on the rising edge of a level input.
module detector_borda (
    input  logic clock_10KHz,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);
    logic level_q;
    always_ff @(posedge clock_10KHz or posedge reset)
        if (reset) level_q <= 1'b0;
        else level_q <= level_in;
    assign pulse_out = level_in & ~level_q;
endmodule

// File: rtl/fila_param.sv
// fila_param: edge-triggered FIFO/LIFO queue; requests detected in IDLE commit one cycle later in OP.
module fila_param
    import fila_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic              clear_in,
    input  logic              mode_lifo_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              overflow_out,
    output logic              underflow_out
);
    localparam int PTR_W = $clog2(DEPTH);
    state_t state, state_nx;
    mode_t mode;
    logic enq_ev, deq_ev, enq_q, deq_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nx, head, top, rd_addr, wr_addr;
    logic [LEN_W-1:0] len, len_nx;
    logic commit, wr_en, pop, pass, ovf_set, udf_set, lifo;

    detector_borda u_enq (.clock_10KHz, .reset, .level_in(enqueue_in), .pulse_out(enq_ev));
    detector_borda u_deq (.clock_10KHz, .reset, .level_in(dequeue_in), .pulse_out(deq_ev));

    assign full_out  = len == LEN_W'(DEPTH);
    assign empty_out = len == '0;
    assign len_out   = len;
    assign lifo      = mode == LIFO;
    // FIFO head is derived from the write pointer so only one pointer needs flushing
    assign head      = wr_ptr - len[PTR_W-1:0];
    assign top       = wr_ptr - PTR_W'(1);

    always_comb begin
        state_nx  = clear_in ? FLUSH : (state == IDLE && (enq_ev || deq_ev)) ? OP : IDLE;
        commit    = state == OP && !clear_in;
        pop       = commit && deq_q && !empty_out;
        pass      = commit && enq_q && deq_q && empty_out;
        wr_en     = commit && enq_q && (deq_q ? !empty_out : !full_out);
        ovf_set   = commit && enq_q && !deq_q && full_out;
        udf_set   = commit && deq_q && !enq_q && empty_out;
        rd_addr   = lifo ? top : head;
        // LIFO pop+push replaces the top in place
        wr_addr   = (lifo && pop) ? top : wr_ptr;
        wr_ptr_nx = (wr_en && !(lifo && pop)) ? wr_ptr + PTR_W'(1) :
                    (lifo && pop && !wr_en) ? top : wr_ptr;
        len_nx    = (wr_en && !pop) ? len + LEN_W'(1) :
                    (pop && !wr_en) ? len - LEN_W'(1) : len;
    end

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mode           <= FIFO;
            enq_q          <= 1'b0;
            deq_q          <= 1'b0;
            data_q         <= '0;
            wr_ptr         <= '0;
            len            <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            overflow_out   <= 1'b0;
            underflow_out  <= 1'b0;
        end else begin
            state          <= state_nx;
            data_valid_out <= pop || pass;
            if (state == IDLE && !clear_in) begin
                enq_q  <= enq_ev;
                deq_q  <= deq_ev;
                data_q <= data_in;
            end
            if (state == FLUSH) begin
                wr_ptr        <= '0;
                len           <= '0;
                overflow_out  <= 1'b0;
                underflow_out <= 1'b0;
            end else begin
                wr_ptr        <= wr_ptr_nx;
                len           <= len_nx;
                overflow_out  <= overflow_out || ovf_set;
                underflow_out <= underflow_out || udf_set;
            end
            if (pop) data_out <= mem[rd_addr];
            else if (pass) data_out <= data_q;
            if (empty_out) mode <= mode_lifo_in ? LIFO : FIFO;
        end
    end

    always_ff @(posedge clock_10KHz)
        if (wr_en) mem[wr_addr] <= data_q;
endmodule

// File: tb/tb_fila_param.sv
// tb_fila_param: directed self-checking bench for fila_param with DEPTH=8, DATA_W=8.
`timescale 1us/1ns
module tb_fila_param;
    logic clock_10KHz = 1'b0;
    logic reset, enqueue_in, dequeue_in, clear_in, mode_lifo_in;
    logic [7:0] data_in, data_out;
    logic data_valid_out, full_out, empty_out, overflow_out, underflow_out;
    logic [3:0] len_out;
    int vecs = 0;
    int errs = 0;

    fila_param #(.DATA_W(8), .DEPTH(8)) dut (
        .clock_10KHz(clock_10KHz), .reset(reset), .enqueue_in(enqueue_in),
        .dequeue_in(dequeue_in), .clear_in(clear_in), .mode_lifo_in(mode_lifo_in),
        .data_in(data_in), .data_out(data_out), .data_valid_out(data_valid_out),
        .len_out(len_out), .full_out(full_out), .empty_out(empty_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out)
    );

    always #50 clock_10KHz = ~clock_10KHz;

    task automatic op(input logic e, input logic d, input logic [7:0] din);
        @(negedge clock_10KHz);
        enqueue_in = e;
        dequeue_in = d;
        data_in = din;
        repeat (2) @(negedge clock_10KHz);
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock_10KHz);
        clear_in = 1'b1;
        @(negedge clock_10KHz);
        clear_in = 1'b0;
        @(negedge clock_10KHz);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        clear_in = 1'b0;
        mode_lifo_in = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clock_10KHz);
        reset = 1'b0;
        vecs++; if (len_out !== 4'd0) begin errs++; $display("FAIL reset_len got %0d exp 0", len_out); end
        vecs++; if (empty_out !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", empty_out); end
        vecs++; if (full_out !== 1'b0) begin errs++; $display("FAIL reset_full got %b exp 0", full_out); end
        vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL reset_data got %h exp 00", data_out); end
        vecs++; if (data_valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", data_valid_out); end
        vecs++; if ({overflow_out, underflow_out} !== 2'b00) begin errs++; $display("FAIL reset_flags got %b exp 00", {overflow_out, underflow_out}); end
    endtask

    task automatic test_fifo_basic();
        logic [7:0] v [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, v[i]);
            vecs++; if (len_out !== 4'(i + 1)) begin errs++; $display("FAIL fifo_enq_len got %0d exp %0d", len_out, i + 1); end
        end
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b1, 8'h00);
            vecs++; if (data_out !== v[i]) begin errs++; $display("FAIL fifo_deq_data got %h exp %h", data_out, v[i]); end
            vecs++; if (data_valid_out !== 1'b1) begin errs++; $display("FAIL fifo_deq_valid got %b exp 1", data_valid_out); end
            vecs++; if (len_out !== 4'(2 - i)) begin errs++; $display("FAIL fifo_deq_len got %0d exp %0d", len_out, 2 - i); end
        end
        vecs++; if (empty_out !== 1'b1) begin errs++; $display("FAIL fifo_empty got %b exp 1", empty_out); end
    endtask

    task automatic test_fill_overflow();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(r * 16 + i));
            vecs++; if (full_out !== 1'b1 || len_out !== 4'd8) begin errs++; $display("FAIL fill_full got full=%b len=%0d exp full=1 len=8", full_out, len_out); end
            if (r == 0) begin
                op(1'b1, 1'b0, 8'hAA);
                vecs++; if (overflow_out !== 1'b1) begin errs++; $display("FAIL overflow_flag got %b exp 1", overflow_out); end
                vecs++; if (len_out !== 4'd8) begin errs++; $display("FAIL overflow_len got %0d exp 8", len_out); end
            end
            for (int i = 0; i < 8; i++) begin
                op(1'b0, 1'b1, 8'h00);
                vecs++; if (data_out !== 8'(r * 16 + i)) begin errs++; $display("FAIL fill_drain got %h exp %h", data_out, 8'(r * 16 + i)); end
            end
            vecs++; if (empty_out !== 1'b1) begin errs++; $display("FAIL fill_empty got %b exp 1", empty_out); end
        end
    endtask

    task automatic test_lifo();
        mode_lifo_in = 1'b1;
        for (int i = 1; i <= 3; i++) op(1'b1, 1'b0, 8'(i));
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'h03) begin errs++; $display("FAIL lifo_pop1 got %h exp 03", data_out); end
        mode_lifo_in = 1'b0;
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'h02) begin errs++; $display("FAIL lifo_pop2_mode_locked got %h exp 02", data_out); end
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'h01) begin errs++; $display("FAIL lifo_pop3 got %h exp 01", data_out); end
        vecs++; if (len_out !== 4'd0) begin errs++; $display("FAIL lifo_len got %0d exp 0", len_out); end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 3; i++) op(1'b1, 1'b0, 8'hA0 + 8'(i));
        op(1'b1, 1'b1, 8'h5A);
        vecs++; if (data_out !== 8'hA1) begin errs++; $display("FAIL sim_data got %h exp a1", data_out); end
        vecs++; if (len_out !== 4'd3) begin errs++; $display("FAIL sim_len got %0d exp 3", len_out); end
        op(1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'h5A) begin errs++; $display("FAIL sim_drain_last got %h exp 5a", data_out); end
        op(1'b1, 1'b1, 8'h77);
        vecs++; if (data_out !== 8'h77) begin errs++; $display("FAIL sim_empty_data got %h exp 77", data_out); end
        vecs++; if (data_valid_out !== 1'b1) begin errs++; $display("FAIL sim_empty_valid got %b exp 1", data_valid_out); end
        vecs++; if (len_out !== 4'd0) begin errs++; $display("FAIL sim_empty_len got %0d exp 0", len_out); end
    endtask

    task automatic test_lifo_full_sim();
        mode_lifo_in = 1'b1;
        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'h80 + 8'(i));
        op(1'b1, 1'b1, 8'hEE);
        vecs++; if (data_out !== 8'h87) begin errs++; $display("FAIL lifo_full_sim_data got %h exp 87", data_out); end
        vecs++; if (len_out !== 4'd8) begin errs++; $display("FAIL lifo_full_sim_len got %0d exp 8", len_out); end
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'hEE) begin errs++; $display("FAIL lifo_full_top got %h exp ee", data_out); end
    endtask

    task automatic test_underflow_clear();
        mode_lifo_in = 1'b0;
        pulse_clear();
        vecs++; if (len_out !== 4'd0 || overflow_out !== 1'b0) begin errs++; $display("FAIL clear1 got len=%0d ovf=%b exp 0 0", len_out, overflow_out); end
        vecs++; if (data_out !== 8'hEE) begin errs++; $display("FAIL clear_keeps_data got %h exp ee", data_out); end
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (underflow_out !== 1'b1) begin errs++; $display("FAIL underflow_flag got %b exp 1", underflow_out); end
        vecs++; if (data_valid_out !== 1'b0) begin errs++; $display("FAIL underflow_valid got %b exp 0", data_valid_out); end
        vecs++; if (data_out !== 8'hEE) begin errs++; $display("FAIL underflow_data got %h exp ee", data_out); end
        pulse_clear();
        vecs++; if ({overflow_out, underflow_out} !== 2'b00) begin errs++; $display("FAIL clear2_flags got %b exp 00", {overflow_out, underflow_out}); end
    endtask

    task automatic test_hold();
        @(negedge clock_10KHz);
        enqueue_in = 1'b1;
        data_in = 8'h99;
        repeat (10) @(negedge clock_10KHz);
        enqueue_in = 1'b0;
        vecs++; if (len_out !== 4'd1) begin errs++; $display("FAIL hold_len got %0d exp 1", len_out); end
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'h99) begin errs++; $display("FAIL hold_data got %h exp 99", data_out); end
    endtask

    task automatic test_reset_mid_op();
        op(1'b1, 1'b0, 8'h44);
        @(negedge clock_10KHz);
        enqueue_in = 1'b1;
        data_in = 8'h55;
        @(negedge clock_10KHz);
        reset = 1'b1;
        enqueue_in = 1'b0;
        @(negedge clock_10KHz);
        reset = 1'b0;
        @(negedge clock_10KHz);
        vecs++; if (len_out !== 4'd0) begin errs++; $display("FAIL midop_len got %0d exp 0", len_out); end
        vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL midop_data got %h exp 00", data_out); end
        op(1'b1, 1'b0, 8'h66);
        vecs++; if (len_out !== 4'd1) begin errs++; $display("FAIL post_reset_enq got %0d exp 1", len_out); end
        op(1'b0, 1'b1, 8'h00);
        vecs++; if (data_out !== 8'h66) begin errs++; $display("FAIL post_reset_deq got %h exp 66", data_out); end
    endtask

    initial begin
        test_reset();
        test_fifo_basic();
        test_fill_overflow();
        test_lifo();
        test_simultaneous();
        test_lifo_full_sim();
        test_underflow_clear();
        test_hold();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
